// File: rtl/spi_master_if.sv
// spi_master_if: word handshake between a producer and the SPI master engine.
// master drives tx words; slave is the engine that accepts them and returns rx.
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data_in;
    logic              tx_valid_in;
    logic              tx_ready_out;
    logic [DATA_W-1:0] rx_data_out;
    logic              rx_valid_out;

    modport master (
        output tx_data_in, tx_valid_in,
        input  tx_ready_out, rx_data_out, rx_valid_out
    );

    modport slave (
        input  tx_data_in, tx_valid_in,
        output tx_ready_out, rx_data_out, rx_valid_out
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI master transfer engine with CPOL/CPHA/LSBFE framing.
// Mode-fault detection on ss_in is built only when SPI_MASTER_MODF_EN is defined.
module spi_master #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk_in,
    input  logic             rstn_in,
    input  logic [7:0]       spi_cr1_in,
    input  logic [DIV_W-1:0] clk_div_in,
    spi_master_if.slave      bus,
    output logic             busy_out,
    output logic             modf_out,
    output logic             sck_out,
    output logic             mosi_out,
    input  logic             miso_in,
    output logic             ss_out,
    input  logic             ss_in
);
    typedef enum logic [1:0] {IDLE, SETUP, TRANS, FINISH} state_t;

    localparam int            EW   = $clog2(2*DATA_W+1);
    localparam logic [EW-1:0] LAST = EW'(2*DATA_W);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_tx, r_rx, r_rx_data, w_rx_ord;
    logic [DIV_W-1:0]  r_div, r_cnt;
    logic [EW-1:0]     r_edge, w_edge_nxt;
    logic              r_cpol, r_cpha, r_lsb, r_ssoe, r_sck;
    logic              r_rx_valid, r_modf;
    logic              w_en, w_active, w_freeze, w_ready, w_accept;
    logic              w_tick, w_abort, w_modf;
    logic              w_odd, w_sample, w_advance;

    assign w_en     = spi_cr1_in[7] & spi_cr1_in[6];
    assign w_active = (r_state != IDLE);
    assign w_freeze = spi_cr1_in[0];

`ifdef SPI_MASTER_MODF_EN
    assign w_modf  = w_active & spi_cr1_in[1] & ~r_ssoe & ~ss_in;
    assign w_ready = (r_state == IDLE) & w_en & ss_in;
`else
    logic w_unused;
    assign w_unused = ss_in ^ spi_cr1_in[1];
    assign w_modf   = 1'b0;
    assign w_ready  = (r_state == IDLE) & w_en;
`endif

    assign w_abort  = w_active & (~w_en | w_modf);
    assign w_accept = bus.tx_valid_in & w_ready;
    assign w_tick   = w_active & ~w_freeze & (r_cnt == r_div);

    // Edge numbering is 1-based; CPHA picks which parity samples.
    assign w_edge_nxt = r_edge + EW'(1);
    assign w_odd      = w_edge_nxt[0];
    assign w_sample   = w_odd ^ r_cpha;
    assign w_advance  = r_cpha ? (w_odd & (w_edge_nxt != EW'(1)))
                               : (~w_odd & (w_edge_nxt != LAST));

    always_comb begin
        w_rx_ord = r_rx;
        if (r_lsb) begin
            for (int i = 0; i < DATA_W; i++) begin
                w_rx_ord[i] = r_rx[DATA_W-1-i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SETUP;
            SETUP:   if (w_tick) w_state_nxt = TRANS;
            TRANS:   if (w_tick && w_edge_nxt == LAST) w_state_nxt = FINISH;
            FINISH:  if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_ssoe     <= 1'b0;
            r_sck      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_modf     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_modf     <= 1'b0;
            if (w_accept) begin
                r_tx   <= bus.tx_data_in;
                r_cpol <= spi_cr1_in[5];
                r_cpha <= spi_cr1_in[4];
                r_ssoe <= spi_cr1_in[3];
                r_lsb  <= spi_cr1_in[2];
                r_div  <= clk_div_in;
                r_sck  <= spi_cr1_in[5];
                r_cnt  <= '0;
                r_edge <= '0;
            end else if (w_abort) begin
                r_modf <= w_modf;
            end else if (w_active && !w_freeze) begin
                r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
                if (w_tick && r_state == TRANS) begin
                    r_sck  <= ~r_sck;
                    r_edge <= w_edge_nxt;
                    if (w_sample) r_rx <= {r_rx[DATA_W-2:0], miso_in};
                    if (w_advance) begin
                        r_tx <= r_lsb ? {1'b0, r_tx[DATA_W-1:1]}
                                      : {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
                if (w_tick && r_state == FINISH) begin
                    r_rx_data  <= w_rx_ord;
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.tx_ready_out = w_ready;
    assign bus.rx_data_out  = r_rx_data;
    assign bus.rx_valid_out = r_rx_valid;
    assign busy_out         = w_active;
    assign modf_out         = r_modf;
    assign sck_out          = w_active ? r_sck : spi_cr1_in[5];
    assign mosi_out         = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign ss_out           = ~(w_active & r_ssoe);
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master (modes, latency, abort, freeze).
// Mode-fault checks are compiled in when SPI_MASTER_MODF_EN is defined.
module tb_spi_master;
    localparam int DW = 8;
    localparam int VW = 8;

    typedef struct {
        logic [7:0] d;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] cr1 = 8'h20;
    logic [7:0] div = 8'd0;
    logic       ss_in = 1'b1;
    logic       miso, sck, mosi, ss, busy, modf;

    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(DW)) bus ();

    spi_master #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk_in     (clk),
        .rstn_in    (rstn),
        .spi_cr1_in (cr1),
        .clk_div_in (div),
        .bus        (bus),
        .busy_out   (busy),
        .modf_out   (modf),
        .sck_out    (sck),
        .mosi_out   (mosi),
        .miso_in    (miso),
        .ss_out     (ss),
        .ss_in      (ss_in)
    );

    int   checks = 0;
    int   fails = 0;
    exp_t q[$];

    logic       use_slave = 1'b0;
    logic [7:0] slave_word = 8'h00;
    int         exp_lat = 0;
    logic       mon_cpol = 1'b0;
    logic       mon_cpha = 1'b0;

    int         cyc = 0, rx_cnt = 0, acc_cnt = 0, modf_cnt = 0;
    int         toggles = 0, rises = 0, falls = 0;
    int         last_rise = -1, gmin = 999, gmax = 0;
    int         ss_hi = 0, ss_hi_at_acc = 0;
    logic [7:0] cap = 8'h00;
    logic       prev_sck = 1'b0;
    time        acc_t = 0;

    // Mode-0 slave: presents MSB first, moves on each falling SCK.
    assign miso = use_slave ? slave_word[~falls[2:0]] : mosi;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ss) ss_hi++;
        if (modf) modf_cnt++;
        if (busy && sck !== prev_sck) begin
            toggles++;
            if (sck) begin
                rises++;
                if (last_rise >= 0) begin
                    if (cyc - last_rise < gmin) gmin = cyc - last_rise;
                    if (cyc - last_rise > gmax) gmax = cyc - last_rise;
                end
                last_rise = cyc;
            end else begin
                falls++;
            end
            if (sck == (mon_cpol == mon_cpha)) cap = {cap[6:0], mosi};
        end
        prev_sck = sck;
        if (bus.rx_valid_out) begin
            rx_cnt++;
            if (q.size() == 0) begin
                chk("rx_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rx_data", 32'(bus.rx_data_out), 32'(e.d));
                if (e.lat > 0) chk("latency", 32'(($time - 5 - acc_t) / 10), 32'(e.lat));
            end
        end
        if (bus.tx_valid_in && bus.tx_ready_out) begin
            e.d = use_slave ? slave_word : bus.tx_data_in;
            e.lat = exp_lat;
            q.push_back(e);
            acc_t = $time + 5;
            acc_cnt++;
            ss_hi_at_acc = ss_hi;
            toggles = 0; rises = 0; falls = 0;
            last_rise = -1; gmin = 999; gmax = 0; cap = 8'h00;
        end
    end

    task automatic send(input logic [7:0] w);
        bit ok = 0;
        @(posedge clk); #1;
        bus.tx_valid_in = 1'b1;
        bus.tx_data_in = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx_ready_out) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.tx_valid_in = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rx_cnt >= n) begin ok = 1; break; end
        end
        if (!ok) chk("rx_timeout", 32'(rx_cnt), 32'(n));
    endtask

    task automatic wait_tog(input int n);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (toggles >= n) begin ok = 1; break; end
        end
        if (!ok) chk("edge_timeout", 32'(toggles), 32'(n));
    endtask

    task automatic wait_acc(input int n);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (acc_cnt >= n) begin ok = 1; break; end
        end
        if (!ok) chk("acc_timeout", 32'(acc_cnt), 32'(n));
    endtask

    initial begin
        int         base, chg;
        logic       s0;
        logic [1:0] m;
        bus.tx_valid_in = 1'b0;
        bus.tx_data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck_cpol", 32'(sck), 32'd1);
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ready", 32'(bus.tx_ready_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rxv", 32'(bus.rx_valid_out), 32'd0);
        chk("rst_rxd", 32'(bus.rx_data_out), 32'd0);
        chk("rst_modf", 32'(modf), 32'd0);
        rstn = 1'b1;
        cr1 = 8'h00;

        // mode 0, div 0, slave answers 0x3C
        cr1 = 8'hC8; div = 8'd0; mon_cpol = 0; mon_cpha = 0;
        use_slave = 1; slave_word = 8'h3C; exp_lat = 18;
        send(8'hA5);
        wait_rx(1);
        chk("t1_mosi_bits", 32'(cap), 32'hA5);
        chk("t1_rises", 32'(rises), 32'd8);
        chk("t1_period", 32'(gmax), 32'd2);
        use_slave = 0;

        // four modes, div 3, LSB first, loopback
        div = 8'd3; exp_lat = 72;
        for (int k = 0; k < 4; k++) begin
            m = 2'(k);
            mon_cpol = m[1]; mon_cpha = m[0];
            cr1 = 8'hCC | {2'b00, m[1], m[0], 4'b0000};
            repeat (2) @(posedge clk);
            #1;
            chk("idle_sck", 32'(sck), 32'(m[1]));
            send(8'h81);
            wait_rx(2 + k);
            chk("mode_rises", 32'(rises), 32'd8);
            chk("mode_pmin", 32'(gmin), 32'd8);
            chk("mode_pmax", 32'(gmax), 32'd8);
            chk("mode_bits", 32'(cap), 32'h81);
        end

        // LSB-first order is visible on the wire
        mon_cpol = 0; mon_cpha = 0; cr1 = 8'hCC;
        send(8'h1E);
        wait_rx(6);
        chk("lsb_bits", 32'(cap), 32'h78);

        // back-to-back with tx_valid held
        cr1 = 8'hC8; div = 8'd0; exp_lat = 18;
        base = acc_cnt;
        @(posedge clk); #1;
        bus.tx_valid_in = 1'b1; bus.tx_data_in = 8'h12;
        wait_acc(base + 1);
        bus.tx_data_in = 8'h34;
        wait_acc(base + 2);
        bus.tx_valid_in = 1'b0;
        chk("b2b_ss_gap", 32'(ss_hi_at_acc >= 1), 32'd1);
        wait_rx(8);

        // SPE cleared mid-frame, CPOL=1
        cr1 = 8'hE8; div = 8'd3; mon_cpol = 1; exp_lat = 72;
        base = rx_cnt;
        send(8'h5A);
        wait_tog(5);
        cr1 = 8'h68;
        void'(q.pop_back());
        @(posedge clk);
        @(negedge clk);
        chk("abort_ss", 32'(ss), 32'd1);
        chk("abort_sck", 32'(sck), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (80) @(posedge clk);
        #1;
        chk("abort_no_rx", 32'(rx_cnt), 32'(base));
        chk("abort_rxd", 32'(bus.rx_data_out), 32'h34);
        chk("abort_rdy_off", 32'(bus.tx_ready_out), 32'd0);
        cr1 = 8'hE8;
        @(negedge clk);
        chk("abort_rdy_on", 32'(bus.tx_ready_out), 32'd1);

        // SPISWAI freeze for 20 cycles
        cr1 = 8'hC8; mon_cpol = 0; exp_lat = 92;
        base = rx_cnt;
        send(8'hC3);
        wait_tog(6);
        cr1 = 8'hC9;
        s0 = sck; chg = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (sck !== s0) chg++;
        end
        chk("frz_sck_held", 32'(chg), 32'd0);
        chk("frz_edges", 32'(toggles), 32'd6);
        cr1 = 8'hC8;
        wait_rx(base + 1);

`ifdef SPI_MASTER_MODF_EN
        cr1 = 8'hC2; exp_lat = 72;
        base = rx_cnt; chg = modf_cnt;
        send(8'h55);
        wait_tog(3);
        ss_in = 1'b0;
        void'(q.pop_back());
        repeat (10) @(posedge clk);
        #1;
        chk("modf_pulse", 32'(modf_cnt - chg), 32'd1);
        chk("modf_busy", 32'(busy), 32'd0);
        chk("modf_rdy_low", 32'(bus.tx_ready_out), 32'd0);
        ss_in = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("modf_no_rx", 32'(rx_cnt), 32'(base));
        chk("modf_rdy_back", 32'(bus.tx_ready_out), 32'd1);
`else
        cr1 = 8'hC2; exp_lat = 72;
        base = rx_cnt;
        send(8'h55);
        wait_tog(3);
        ss_in = 1'b0;
        wait_rx(base + 1);
        chk("modf_tied", 32'(modf_cnt), 32'd0);
        ss_in = 1'b1;
`endif

        repeat (5) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
